// File: rtl/uart_boot_sequencer.sv
// uart_boot_sequencer
//   Boot/load controller sitting between the UART byte receiver/transmitter
//   and the pipeline core. While the core is held in reset it parses a framed
//   program image:
//     SYNC, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CHK
//   where CHK is the XOR of the data bytes only. Each complete word is written
//   to instruction memory. The frame is answered with one TX byte, ACK (8'h06)
//   or NAK (8'h15). After an ACK the core is released.
//
// Parameters
//   ADDR_W       imem word-address width, DEPTH = 2**ADDR_W words
//   SYNC_BYTE    frame start byte
//   TIMEOUT_CYC  inter-byte timeout in clock cycles (BOOT_TIMEOUT_EN only)
//
// Optional feature macro: BOOT_TIMEOUT_EN
//   Defined   : a stalled frame (LEN_LO, LEN_HI, DATA, CHECK) is NAKed once
//               TIMEOUT_CYC cycles pass without an rx byte.
//   Undefined : no counter; a stalled frame waits forever.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_rx_valid, i_rx_data     1-cycle strobe with received byte
//   i_tx_ready                transmitter accepts o_tx_data
//   o_tx_valid, o_tx_data     response byte, held until i_tx_ready
//   i_boot_req                level; returns a running core to IDLE
//   o_imem_we/addr/wdata      instruction-memory write port
//   o_cpu_hold                1 = core held in reset
//   o_load_ok                 1 = last frame accepted, core running
module uart_boot_sequencer #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_boot_req,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_ok
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_RESP, S_RUN
  } state_t;

  state_t            r_state;
  logic [15:0]       r_len;     // words still to receive
  logic [1:0]        r_idx;     // byte lane within the current word
  logic [7:0]        r_chk;
  logic [31:0]       r_word;    // assembly buffer, keeps o_imem_wdata stable
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_cpu_hold;
  logic              r_load_ok;
  logic [15:0]       w_len;

  // Full word count as it becomes known in LEN_HI.
  assign w_len = {i_rx_data, r_len[7:0]};

`ifdef BOOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to;
  logic            w_to_hit;
  assign w_to_hit = (r_to == TO_W'(TIMEOUT_CYC - 1)) && !i_rx_valid;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_chk      <= '0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_cpu_hold <= 1'b1;
      r_load_ok  <= 1'b0;
`ifdef BOOT_TIMEOUT_EN
      r_to       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      // The address advances right after the write cycle that used it.
      if (r_we) r_addr <= r_addr + 1'b1;
`ifdef BOOT_TIMEOUT_EN
      if (i_rx_valid) r_to <= '0;
      else if (r_to != TO_W'(TIMEOUT_CYC - 1)) r_to <= r_to + 1'b1;
`endif
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
            r_state <= S_LEN_LO;
`ifdef BOOT_TIMEOUT_EN
            r_to    <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (i_rx_valid) begin
            r_len[7:0] <= i_rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (i_rx_valid) begin
            r_len[15:8] <= i_rx_data;
            if (32'(w_len) > DEPTH) begin
              r_state    <= S_RESP;
              r_tx_valid <= 1'b1;
              r_tx_data  <= NAK;
            end else if (w_len == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (i_rx_valid) begin
            r_word[{r_idx, 3'b000} +: 8] <= i_rx_data;
            r_chk <= r_chk ^ i_rx_data;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_wdata <= {i_rx_data, r_word[23:0]};
              r_we    <= 1'b1;
              r_len   <= r_len - 16'd1;
              if (r_len == 16'd1) r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (i_rx_valid) begin
            r_state    <= S_RESP;
            r_tx_valid <= 1'b1;
            r_tx_data  <= (i_rx_data == r_chk) ? ACK : NAK;
          end
        end
        S_RESP: begin
          // rx bytes arriving here are dropped.
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            if (r_tx_data == ACK) begin
              r_state    <= S_RUN;
              r_cpu_hold <= 1'b0;
              r_load_ok  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_addr  <= '0;
              r_idx   <= '0;
              r_chk   <= '0;
            end
          end
        end
        S_RUN: begin
          if (i_boot_req) begin
            r_state    <= S_IDLE;
            r_cpu_hold <= 1'b1;
            r_load_ok  <= 1'b0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_chk      <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef BOOT_TIMEOUT_EN
      // A stalled frame is abandoned with a NAK; overrides the case above.
      if (w_to_hit && (r_state == S_LEN_LO || r_state == S_LEN_HI ||
                       r_state == S_DATA   || r_state == S_CHECK)) begin
        r_state    <= S_RESP;
        r_tx_valid <= 1'b1;
        r_tx_data  <= NAK;
      end
`endif
    end
  end

  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = r_tx_data;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_ok    = r_load_ok;

endmodule
